// File: rtl/multicycle_control.sv
// Control sequencer for a multi-cycle MIPS datapath: FETCH/DECODE/EXEC/MEM/WB with a
// memory handshake, a bounded memory wait, illegal-instruction trapping and a retired count.
module multicycle_control #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ir_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             i_or_d,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             call,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [3:0]       alu_op,
  output logic             ext_op,
  output logic [1:0]       npc_op,
  output logic [2:0]       state,
  output logic             instr_done,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] instr_count
);

  localparam int unsigned WAIT_W = (TIMEOUT_CYCLES <= 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  localparam logic [3:0] ALU_SHIFT = 4'b0000;
  localparam logic [3:0] ALU_ADD   = 4'b0001;
  localparam logic [3:0] ALU_SUB   = 4'b0010;
  localparam logic [3:0] ALU_AND   = 4'b0011;
  localparam logic [3:0] ALU_OR    = 4'b0100;
  localparam logic [3:0] ALU_SLT   = 4'b0101;
  localparam logic [3:0] ALU_SLTU  = 4'b0110;
  localparam logic [3:0] ALU_LUI   = 4'b1100;
  localparam logic [3:0] ALU_XOR   = 4'b1101;
  localparam logic [3:0] ALU_NOR   = 4'b1110;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_ERR    = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    C_ILL,
    C_RALU,
    C_IALU,
    C_LOAD,
    C_STORE,
    C_BEQ,
    C_BNE,
    C_J,
    C_JAL,
    C_JR,
    C_JALR
  } cls_t;

  state_t            r_state;
  logic [WAIT_W-1:0] r_wait;
  logic [1:0]        r_err;
  logic [CNT_W-1:0]  r_count;

  state_t            w_next;
  logic [1:0]        w_err_next;
  cls_t              w_cls;
  logic [3:0]        w_alu_op;
  logic              w_sext;
  logic              w_wait_last;

  assign state       = r_state;
  assign err_code    = r_err;
  assign instr_count = r_count;
  assign w_wait_last = (r_wait == WAIT_LAST);

  // Instruction class, ALU operation and immediate extension from the IR fields
  always_comb begin
    w_cls    = C_ILL;
    w_alu_op = ALU_SHIFT;
    w_sext   = 1'b0;
    case (opcode)
      6'h00: begin
        w_cls = C_RALU;
        case (funct)
          6'h20, 6'h21: w_alu_op = ALU_ADD;
          6'h22, 6'h23: w_alu_op = ALU_SUB;
          6'h24:        w_alu_op = ALU_AND;
          6'h25:        w_alu_op = ALU_OR;
          6'h26:        w_alu_op = ALU_XOR;
          6'h27:        w_alu_op = ALU_NOR;
          6'h2A:        w_alu_op = ALU_SLT;
          6'h2B:        w_alu_op = ALU_SLTU;
          6'h00, 6'h02, 6'h03,
          6'h04, 6'h06, 6'h07: w_alu_op = ALU_SHIFT;
          6'h08:        w_cls = C_JR;
          6'h09:        w_cls = C_JALR;
          default:      w_cls = C_ILL;
        endcase
      end
      6'h02: w_cls = C_J;
      6'h03: w_cls = C_JAL;
      6'h04: w_cls = C_BEQ;
      6'h05: w_cls = C_BNE;
      6'h08: begin w_cls = C_IALU; w_alu_op = ALU_ADD; w_sext = 1'b1; end
      6'h0A: begin w_cls = C_IALU; w_alu_op = ALU_SLT; w_sext = 1'b1; end
      6'h0C: begin w_cls = C_IALU; w_alu_op = ALU_AND; end
      6'h0D: begin w_cls = C_IALU; w_alu_op = ALU_OR;  end
      6'h0F: begin w_cls = C_IALU; w_alu_op = ALU_LUI; end
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: w_cls = C_LOAD;
      6'h28, 6'h29, 6'h2B:               w_cls = C_STORE;
      default: w_cls = C_ILL;
    endcase
  end

  // Per-state datapath strobes and next-state selection
  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    i_or_d     = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    call       = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 4'b0000;
    ext_op     = 1'b0;
    npc_op     = 2'b00;
    instr_done = 1'b0;
    w_next     = r_state;
    w_err_next = r_err;
    case (r_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        alu_op    = ALU_ADD;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          w_next   = S_DECODE;
        end else if (w_wait_last) begin
          w_next     = S_ERR;
          w_err_next = ERR_TIMEOUT;
        end
      end
      S_DECODE: begin
        case (w_cls)
          C_ILL: begin
            w_next     = S_ERR;
            w_err_next = ERR_ILLEGAL;
          end
          C_J, C_JAL: begin
            pc_write   = 1'b1;
            npc_op     = 2'b10;
            reg_write  = (w_cls == C_JAL);
            call       = (w_cls == C_JAL);
            instr_done = 1'b1;
            w_next     = S_FETCH;
          end
          default: w_next = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (w_cls)
          C_RALU: begin
            alu_src_a = 1'b1;
            alu_op    = w_alu_op;
            w_next    = S_WB;
          end
          C_IALU: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            alu_op    = w_alu_op;
            ext_op    = w_sext;
            w_next    = S_WB;
          end
          C_LOAD, C_STORE: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            alu_op    = ALU_ADD;
            ext_op    = 1'b1;
            w_next    = S_MEM;
          end
          C_BEQ, C_BNE: begin
            alu_src_a  = 1'b1;
            alu_op     = ALU_SUB;
            npc_op     = 2'b01;
            pc_write   = (w_cls == C_BEQ) ? zero : ~zero;
            instr_done = 1'b1;
            w_next     = S_FETCH;
          end
          C_JR, C_JALR: begin
            pc_write   = 1'b1;
            npc_op     = 2'b11;
            reg_write  = (w_cls == C_JALR);
            call       = (w_cls == C_JALR);
            reg_dst    = (w_cls == C_JALR);
            instr_done = 1'b1;
            w_next     = S_FETCH;
          end
          default: begin
            w_next     = S_ERR;
            w_err_next = ERR_ILLEGAL;
          end
        endcase
      end
      S_MEM: begin
        i_or_d    = 1'b1;
        mem_read  = (w_cls == C_LOAD);
        mem_write = (w_cls == C_STORE);
        if (mem_ready) begin
          if (w_cls == C_STORE) begin
            instr_done = 1'b1;
            w_next     = S_FETCH;
          end else begin
            w_next = S_WB;
          end
        end else if (w_wait_last) begin
          w_next     = S_ERR;
          w_err_next = ERR_TIMEOUT;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (w_cls == C_LOAD);
        reg_dst    = (w_cls == C_RALU);
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end
      S_ERR: w_next = S_ERR;
      default: w_next = S_ERR;
    endcase
  end

  // State, wait counter, sticky error and retired-instruction counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_wait  <= '0;
      r_err   <= ERR_NONE;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      r_err   <= w_err_next;
      if (w_next != r_state) begin
        r_wait <= '0;
      end else if (r_state == S_FETCH || r_state == S_MEM) begin
        r_wait <= r_wait + WAIT_W'(1);
      end
      if (instr_done) begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Multi-cycle successor to the single-cycle control decoder. It sequences each MIPS instruction through FETCH/DECODE/EXEC/MEM/WB states and drives datapath strobes per state. It handshakes with a shared instruction/data memory via mem_ready, has a parametrised memory-wait timeout, flags illegal opcodes, and keeps a retired-instruction counter. It sits between the IR/flag outputs of the multi-cycle datapath and its register-enable and mux-select inputs.

Parameters:
TIMEOUT_CYCLES, 16, maximum cycles spent waiting for mem_ready in FETCH or MEM before the error state is entered (legal range 2..256).
CNT_W, 32, width of the retired-instruction counter.

Ports:
clk  in  1  clock; all state changes on the rising edge
rst  in  1  synchronous, active-high reset
opcode  in  6  IR[31:26]; stable from DECODE until the instruction ends
funct  in  6  IR[5:0]
zero  in  1  ALU zero flag, valid in EXEC
mem_ready  in  1  memory completes the current access this cycle
pc_write  out  1  load PC from npc source
ir_write  out  1  load IR from memory read data
mem_read  out  1  memory read request (fetch or load)
mem_write  out  1  memory write request (store)
i_or_d  out  1  memory address select: 0 = PC, 1 = ALU result
reg_write  out  1  register file write enable
reg_dst  out  1  1 = rd, 0 = rt
mem_to_reg  out  1  1 = write-back from memory data register
call  out  1  jal/jalr: write PC+4 to $31 or rd
alu_src_a  out  1  0 = PC, 1 = rs
alu_src_b  out  2  00 = rt, 01 = constant 4, 10 = extended immediate
alu_op  out  4  ALU operation code
ext_op  out  1  1 = sign-extend immediate, 0 = zero-extend
npc_op  out  2  00 = PC+4, 01 = branch target, 10 = jump target, 11 = rs
state  out  3  current state: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, ERR=7
instr_done  out  1  one-cycle pulse on the final cycle of each instruction
err_code  out  2  00 = none, 01 = illegal instruction, 10 = memory timeout
instr_count  out  CNT_W  retired instruction count

Behaviour:
- All outputs are combinational functions of state and opcode/funct. Only state, the wait counter, err_code and instr_count are registered.
- Reset: state=FETCH, wait counter=0, err_code=0, instr_count=0. Reset mid-instruction aborts the instruction with no strobes on the following cycle. All strobes are 0 except the FETCH strobes described next.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=0001.
  - On mem_ready: ir_write=1, pc_write=1, npc_op=00, then go to DECODE.
  - Otherwise stay in FETCH and increment the wait counter.
- DECODE: classify the instruction.
  - Unsupported opcode/funct: go to ERR with err_code=01.
  - j: pc_write=1, npc_op=10, then FETCH.
  - jal: additionally reg_write=1, call=1.
  - All other instructions: go to EXEC.
- EXEC:
  - R-ALU: alu_src_a=1, alu_src_b=00. Shift instructions are included. Go to WB.
  - I-ALU (addi, ori, andi, slti, lui): alu_src_b=10, then WB. ext_op=1 only for addi and slti.
  - Load/store: alu_op=0001, alu_src_b=10, ext_op=1, then MEM.
  - beq/bne: alu_op=0010, npc_op=01. pc_write = beq&zero | bne&~zero. Then FETCH with instr_done=1.
  - jr/jalr: pc_write=1, npc_op=11, then FETCH. jalr also asserts reg_write=1 and call=1.
- alu_op codes: add/addu/addi=0001, sub/subu=0010, and/andi=0011, or/ori=0100, slt/slti=0101, sltu=0110, lui=1100, xor=1101, nor=1110, shifts=0000 (shifter path).
- MEM: i_or_d=1. Loads (lw, lb, lbu, lh, lhu) assert mem_read; stores (sw, sb, sh) assert mem_write. The request is held until mem_ready.
  - Store with mem_ready: go to FETCH with instr_done=1.
  - Load with mem_ready: go to WB.
- WB: reg_write=1, then FETCH with instr_done=1.
  - mem_to_reg=1 for loads.
  - reg_dst=1 for R-ALU only.
- Wait counter: cleared on every state entry. If it reaches TIMEOUT_CYCLES-1 in FETCH or MEM without mem_ready, go to ERR with err_code=10. mem_ready arriving on that same cycle wins, and no error is raised.
- ERR: sticky until rst. All strobes are 0 and instr_count is frozen.
- instr_count increments on each instr_done and wraps at 2^CNT_W.
- Latency with zero-wait memory:
  - j/jal: 2 cycles
  - branch, jr/jalr: 3 cycles
  - R-ALU/I-ALU, store: 4 cycles
  - load: 5 cycles

Test Plan:
- Reset, then add (opcode 0, funct 0x20) with mem_ready=1: states 0,1,2,4. reg_write=1 and reg_dst=1 in WB. instr_done on cycle 4. instr_count=1.
- lw (0x23) with mem_ready low for 3 cycles in MEM: mem_read and i_or_d held for 4 cycles. WB asserts mem_to_reg=1. No error.
- beq (0x04) with zero=1, then with zero=0: pc_write=1 with npc_op=01 in EXEC for the first case; pc_write=0 for the second. Both take 3 cycles.
- jal (0x03): on the DECODE cycle pc_write=1, npc_op=10, reg_write=1, call=1, instr_done=1.
- mem_ready held low in FETCH with TIMEOUT_CYCLES=16: after 16 cycles state=7, err_code=10, all strobes 0. A later rst pulse returns to state 0 with err_code=0.
- Opcode 0x3F: DECODE goes to ERR, err_code=01, instr_count unchanged. rst asserted during MEM of a sw: no mem_write on the next cycle, state=0.
